// File: rtl/ti_adc_cap_pkg.sv
// Shared types and helpers for the TI-ADC snapshot capture buffer.
package ti_adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READ
  } cap_state_t;

  localparam int unsigned DEF_ADC_WAYS = 8;
  localparam int unsigned DEF_ADC_BITS = 9;

  // Default-geometry sample word; modules with other geometries declare their own.
  typedef logic [DEF_ADC_WAYS-1:0][DEF_ADC_BITS-1:0] sample_word_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ti_adc_capture_cap_ram.sv
// Simple dual-port capture RAM: one write port, one synchronous read port.
module cap_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 72,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ti_adc_capture.sv
// Snapshot capture buffer for the TI-ADC: pre/post-trigger capture into a
// circular RAM, then oldest-first readout over a valid/ready port.
module ti_adc_capture
  import ti_adc_cap_pkg::*;
#(
  parameter  int unsigned ADC_WAYS = 8,
  parameter  int unsigned ADC_BITS = 9,
  parameter  int unsigned DEPTH    = 256,
  localparam int unsigned AW       = addr_width(DEPTH)
) (
  input  logic                core_clk,
  input  logic                rst,
  input  logic [ADC_BITS-1:0] adc_data [0:ADC_WAYS-1],
  input  logic                arm,
  input  logic                abort,
  input  logic                trig_mode,
  input  logic [ADC_BITS-1:0] trig_level,
  input  logic [AW-1:0]       pre_count,
  output logic                busy,
  output logic                done,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [ADC_BITS-1:0] rd_data [0:ADC_WAYS-1],
  output logic                rd_last
);

  typedef logic [ADC_WAYS-1:0][ADC_BITS-1:0] word_t;
  localparam int unsigned WW = $bits(word_t);
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [AW-1:0] A_MAX = AW'(DEPTH - 1);

  cap_state_t state_q, state_d;
  word_t      s_word_q, s_word_d, p_word_q, p_word_d;
  logic [AW-1:0] pc_q, pc_d, wr_ptr_q, wr_ptr_d, post_left_q, post_left_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic       out_v_q, out_v_d, out_last_q, out_last_d;
  logic       skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  word_t      out_data_q, out_data_d, skid_data_q, skid_data_d;

  logic          wr_en, rd_en, rise, trig_hit, pop;
  logic [1:0]    occ;
  logic [WW-1:0] ram_rdata;

  cap_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WW),
    .AW    (AW)
  ) u_ram (
    .clk     (core_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_word_q),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  always_comb begin
    s_word_d = s_word_q;
    for (int unsigned i = 0; i < ADC_WAYS; i++) s_word_d[i] = adc_data[i];
    p_word_d = s_word_q;
  end

  // Rising crossing anywhere in the word; way 0 looks back into the previous word.
  always_comb begin
    rise = (s_word_q[0] >= trig_level) && (p_word_q[ADC_WAYS-1] < trig_level);
    for (int unsigned i = 1; i < ADC_WAYS; i++) begin
      if ((s_word_q[i] >= trig_level) && (s_word_q[i-1] < trig_level)) rise = 1'b1;
    end
    trig_hit = !trig_mode || rise;
  end

  assign wr_en = !abort && (state_q inside {PRE, WAIT_TRIG, POST});
  assign pop   = out_v_q && rd_ready;
  assign occ   = 2'(out_v_q) + 2'(skid_v_q) + 2'(ram_vld_q);
  // A read is only launched when the output/skid pair is guaranteed to have room for it.
  assign rd_en = !abort && (state_q == READ) && (rd_cnt_q != (AW+1)'(DEPTH))
                 && ((occ - 2'(pop)) < 2'd2);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    post_left_d = post_left_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (arm && !abort) begin
          pc_d     = pre_count;
          wr_ptr_d = '0;
          done_d   = 1'b0;
          state_d  = (pre_count == '0) ? WAIT_TRIG : PRE;
        end
      end
      PRE: begin
        wr_ptr_d = wr_ptr_q + A_ONE;
        if (wr_ptr_q == pc_q - A_ONE) state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        wr_ptr_d = wr_ptr_q + A_ONE;
        if (trig_hit) begin
          rd_ptr_d    = wr_ptr_q - pc_q;
          rd_cnt_d    = '0;
          post_left_d = A_MAX - pc_q;
          state_d     = (pc_q == A_MAX) ? READ : POST;
        end
      end
      POST: begin
        wr_ptr_d    = wr_ptr_q + A_ONE;
        post_left_d = post_left_q - A_ONE;
        if (post_left_q == A_ONE) state_d = READ;
      end
      READ: begin
        if (rd_en) begin
          rd_ptr_d = rd_ptr_q + A_ONE;
          rd_cnt_d = rd_cnt_q + (AW+1)'(1);
        end
        if (pop && out_last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    ram_vld_d   = rd_en;
    ram_last_d  = rd_en && (rd_cnt_q == (AW+1)'(DEPTH - 1));
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;

    if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_v_d   = ram_vld_q;
        if (ram_vld_q) begin
          skid_data_d = ram_rdata;
          skid_last_d = ram_last_q;
        end
      end else if (ram_vld_q) begin
        out_v_d    = 1'b1;
        out_data_d = ram_rdata;
        out_last_d = ram_last_q;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = ram_rdata;
      skid_last_d = ram_last_q;
    end

    if (abort) begin
      ram_vld_d = 1'b0;
      out_v_d   = 1'b0;
      skid_v_d  = 1'b0;
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_word_q    <= '0;
      p_word_q    <= '0;
      pc_q        <= '0;
      wr_ptr_q    <= '0;
      post_left_q <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_word_q    <= s_word_d;
      p_word_q    <= p_word_d;
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      post_left_q <= post_left_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = out_v_q;
  assign rd_last  = out_v_q && out_last_q;

  always_comb begin
    for (int unsigned i = 0; i < ADC_WAYS; i++) rd_data[i] = out_data_q[i];
  end

endmodule
